buffer_to_mpf_sm: RTL and testbench
===================================

BUFFER_TO_MPF_SM -- requirements
Module: buffer_to_mpf_SM

Interface
REQ-001 Parameter CL_ADDR_WIDTH, default 42: cache-line address width.
REQ-002 Parameter DATA_WIDTH, default 512: cache-line data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  start request; sampled only in IDLE.
REQ-006 data_length  input  64  number of cache lines to write; latched at start.
REQ-007 first_clAddr  input  CL_ADDR_WIDTH  host cache-line address of line 0; latched at start.
REQ-008 done  output  1  transfer complete, all write responses received.
REQ-009 empty_n  input  1  buffer holds at least one line; buffer_data is valid (first-word-fall-through).
REQ-010 buffer_data  input  DATA_WIDTH  head line of buffer.
REQ-011 buffer_rd_enable  output  1  pops buffer head this cycle.
REQ-012 c1Tx_valid  output  1  write request valid, one cycle per line.
REQ-013 c1Tx_addr  output  CL_ADDR_WIDTH  write request cache-line address.
REQ-014 c1Tx_data  output  DATA_WIDTH  write request payload.
REQ-015 c1Tx_mdata  output  16  request tag = low 16 bits of line index.
REQ-016 c1TxAlmFull  input  1  channel almost full; no new request may be started while high.
REQ-017 c1Rx_wrRsp_valid  input  1  one write response (one line) received this cycle.

Function
REQ-018 States: IDLE, SEND, WAIT_RSP, DONE.
REQ-019 IDLE: run=1 -> latch data_length into len, first_clAddr into base, clear sent/rsp counters; next state SEND if len!=0, DONE if len==0.
REQ-020 SEND: buffer_rd_enable = empty_n & ~c1TxAlmFull & (sent<len), combinational, asserted at most once per cycle.
REQ-021 On buffer_rd_enable, next cycle: c1Tx_valid=1, c1Tx_data=buffer_data popped, c1Tx_addr=base+sent (modulo 2^CL_ADDR_WIDTH), c1Tx_mdata=sent[15:0]; sent increments.
REQ-022 Cycles without buffer_rd_enable -> c1Tx_valid=0; c1Tx_addr/data/mdata hold last value.
REQ-023 Latency: buffer pop to c1Tx_valid exactly 1 cycle; back-to-back lines sustain one request per cycle.
REQ-024 empty_n=0 or c1TxAlmFull=1 stalls SEND without losing count; resumes on first cycle both clear.
REQ-025 SEND -> WAIT_RSP in the cycle after the pop that makes sent==len.
REQ-026 rsp counter increments on every c1Rx_wrRsp_valid in SEND or WAIT_RSP, saturating at len; responses in IDLE/DONE ignored.
REQ-027 WAIT_RSP -> DONE when rsp==len (incl. the increment of that cycle); if all responses arrive during SEND, WAIT_RSP lasts one cycle.
REQ-028 DONE: done=1 (registered); remains until run=0, then IDLE with done=0 next cycle.
REQ-029 run changes and data_length/first_clAddr changes outside IDLE have no effect.
REQ-030 sent, rsp, len counters are 64 bits; no overflow for any legal data_length.

Reset
REQ-031 reset=0 asynchronously forces IDLE, done=0, c1Tx_valid=0, buffer_rd_enable=0, c1Tx_addr/data/mdata=0, all counters 0.
REQ-032 Reset asserted mid-transfer aborts it; no request is issued until a new start after reset release.
REQ-033 First start accepted on the first rising edge with reset=1 and run=1.

Verification
REQ-034 len=4, base=0x100, buffer preloaded 4 lines, responses 2 cycles after each request -> c1Tx_valid 4 consecutive cycles, addrs 0x100..0x103, mdata 0..3, done after 4th response.
REQ-035 len=0, run=1 -> DONE in 1 cycle, no buffer_rd_enable, no c1Tx_valid; run=0 -> done=0 next cycle.
REQ-036 len=8, empty_n toggles every 3 cycles, c1TxAlmFull high for 5 cycles mid-transfer -> exactly 8 requests, in-order data and addrs, none while almost full.
REQ-037 len=3, base=2^42-2 -> addrs 2^42-2, 2^42-1, 0.
REQ-038 len=6, reset pulsed low after 3rd request -> outputs zero immediately, IDLE; restart len=2 completes with mdata 0,1.
REQ-039 len=2, extra response after done and in IDLE -> done unaffected, counters unchanged.

Source files
------------

// File: rtl/buffer_to_mpf_sm.sv
// rtl/buffer_to_mpf_sm.sv - streams buffered cache lines to the MPF write channel and counts write responses
module buffer_to_mpf_sm #(
    parameter int CL_ADDR_WIDTH = 42,
    parameter int DATA_WIDTH    = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [63:0]              data_length,
    input  logic [CL_ADDR_WIDTH-1:0] first_clAddr,
    output logic                     done,
    input  logic                     empty_n,
    input  logic [DATA_WIDTH-1:0]    buffer_data,
    output logic                     buffer_rd_enable,
    output logic                     c1Tx_valid,
    output logic [CL_ADDR_WIDTH-1:0] c1Tx_addr,
    output logic [DATA_WIDTH-1:0]    c1Tx_data,
    output logic [15:0]              c1Tx_mdata,
    input  logic                     c1TxAlmFull,
    input  logic                     c1Rx_wrRsp_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                   state;
    logic [63:0]              len;
    logic [63:0]              sent;
    logic [63:0]              rsp;
    logic [CL_ADDR_WIDTH-1:0] base;

    logic                     rsp_inc;
    logic [63:0]              rsp_next;
    logic                     last_pop;

    // The pop is combinational so the buffer head is consumed in the same
    // cycle it is judged sendable; the request itself is registered below.
    assign buffer_rd_enable = (state == SEND) && empty_n && !c1TxAlmFull && (sent < len);

    // Responses count only while a transfer is in flight and never past len.
    assign rsp_inc  = ((state == SEND) || (state == WAIT_RSP)) && c1Rx_wrRsp_valid && (rsp < len);
    assign rsp_next = rsp + {63'd0, rsp_inc};
    assign last_pop = buffer_rd_enable && ((sent + 64'd1) == len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            len        <= 64'd0;
            sent       <= 64'd0;
            rsp        <= 64'd0;
            base       <= '0;
            c1Tx_valid <= 1'b0;
            c1Tx_addr  <= '0;
            c1Tx_data  <= '0;
            c1Tx_mdata <= 16'd0;
        end else begin
            c1Tx_valid <= buffer_rd_enable;
            if (buffer_rd_enable) begin
                c1Tx_data  <= buffer_data;
                c1Tx_addr  <= base + sent[CL_ADDR_WIDTH-1:0];
                c1Tx_mdata <= sent[15:0];
                sent       <= sent + 64'd1;
            end

            if (rsp_inc) begin
                rsp <= rsp_next;
            end

            case (state)
                IDLE: begin
                    if (run) begin
                        len  <= data_length;
                        base <= first_clAddr;
                        sent <= 64'd0;
                        rsp  <= 64'd0;
                        if (data_length == 64'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (last_pop) begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // rsp_next already includes a response landing this cycle.
                    if (rsp_next == len) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!run) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_to_mpf_sm.sv
// tb/tb_buffer_to_mpf_sm.sv - directed self-checking bench for buffer_to_mpf_sm
module tb_buffer_to_mpf_sm;

    localparam int CLW = 42;
    localparam int DW  = 512;

    logic           clk = 1'b0;
    logic           reset;
    logic           run;
    logic [63:0]    data_length;
    logic [CLW-1:0] first_clAddr;
    logic           done;
    logic           empty_n;
    logic [DW-1:0]  buffer_data;
    logic           buffer_rd_enable;
    logic           c1Tx_valid;
    logic [CLW-1:0] c1Tx_addr;
    logic [DW-1:0]  c1Tx_data;
    logic [15:0]    c1Tx_mdata;
    logic           c1TxAlmFull;
    logic           c1Rx_wrRsp_valid;

    always #5 clk = ~clk;

    buffer_to_mpf_sm #(
        .CL_ADDR_WIDTH(CLW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .data_length     (data_length),
        .first_clAddr    (first_clAddr),
        .done            (done),
        .empty_n         (empty_n),
        .buffer_data     (buffer_data),
        .buffer_rd_enable(buffer_rd_enable),
        .c1Tx_valid      (c1Tx_valid),
        .c1Tx_addr       (c1Tx_addr),
        .c1Tx_data       (c1Tx_data),
        .c1Tx_mdata      (c1Tx_mdata),
        .c1TxAlmFull     (c1TxAlmFull),
        .c1Rx_wrRsp_valid(c1Rx_wrRsp_valid)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]  bq[$];
    logic [CLW-1:0] got_addr[$];
    logic [DW-1:0]  got_data[$];
    logic [15:0]    got_mdata[$];
    int             got_cyc[$];

    logic       buf_gate;
    logic       auto_rsp;
    logic       force_rsp;
    logic [2:0] rsp_pipe;
    int         cyc;
    int         done_cyc;
    int         rd_count;
    int         alm_viol;
    int         start_cyc;

    function automatic logic [DW-1:0] mk_line(input logic [31:0] v);
        return {16{v}};
    endfunction

    task automatic clear_tb();
        bq.delete();
        got_addr.delete();
        got_data.delete();
        got_mdata.delete();
        got_cyc.delete();
        rsp_pipe  = 3'd0;
        done_cyc  = -1;
        rd_count  = 0;
        alm_viol  = 0;
        auto_rsp  = 1'b0;
        force_rsp = 1'b0;
        buf_gate  = 1'b1;
    endtask

    // One clock cycle: drive inputs, sample the combinational pop, clock,
    // then sample registered outputs 1 time unit after the edge.
    task automatic tick();
        logic          saw_rd;
        logic [DW-1:0] dummy;
        empty_n          = buf_gate && (bq.size() != 0);
        buffer_data      = (bq.size() != 0) ? bq[0] : '0;
        c1Rx_wrRsp_valid = (rsp_pipe[0] && auto_rsp) || force_rsp;
        #1;
        saw_rd = buffer_rd_enable;
        if (saw_rd && c1TxAlmFull) alm_viol++;
        if (saw_rd) rd_count++;
        @(posedge clk);
        cyc++;
        if (saw_rd && bq.size() != 0) dummy = bq.pop_front();
        #1;
        rsp_pipe    = rsp_pipe >> 1;
        rsp_pipe[2] = c1Tx_valid;
        if (c1Tx_valid) begin
            got_addr.push_back(c1Tx_addr);
            got_data.push_back(c1Tx_data);
            got_mdata.push_back(c1Tx_mdata);
            got_cyc.push_back(cyc);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    // Start a transfer, then scramble the start inputs to prove they are latched.
    task automatic start(input logic [63:0] len, input logic [CLW-1:0] base);
        data_length  = len;
        first_clAddr = base;
        run          = 1'b1;
        tick();
        start_cyc    = cyc;
        data_length  = 64'd99;
        first_clAddr = '1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (done_cyc >= 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_tb();
        reset = 1'b0;
        run   = 1'b0;
        bq.push_back(mk_line(32'h1));
        tick();
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (c1Tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", c1Tx_valid); end
        checks++; if (buffer_rd_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", buffer_rd_enable); end
        checks++; if (c1Tx_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", c1Tx_addr); end
        checks++; if (c1Tx_mdata !== 16'd0) begin errors++; $display("FAIL reset_mdata got=%h exp=0", c1Tx_mdata); end
        checks++; if (c1Tx_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", c1Tx_data); end
        reset = 1'b1;
        bq.delete();
    endtask

    task automatic test_basic();
        logic [CLW-1:0] exp_addr [4] = '{42'h100, 42'h101, 42'h102, 42'h103};
        bit ok;
        clear_tb();
        for (int i = 0; i < 4; i++) bq.push_back(mk_line(32'hA000_0000 + i));
        auto_rsp = 1'b1;
        start(64'd4, 42'h100);
        wait_done(40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_timeout got=%b exp=1", ok); end
        checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL basic_req_count got=%0d exp=4", got_addr.size()); end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            checks++; if (got_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, got_addr[i], exp_addr[i]); end
            checks++; if (got_mdata[i] !== 16'(i)) begin errors++; $display("FAIL basic_mdata[%0d] got=%0d exp=%0d", i, got_mdata[i], i); end
            checks++; if (got_data[i] !== mk_line(32'hA000_0000 + i)) begin errors++; $display("FAIL basic_data[%0d] got=%h", i, got_data[i][31:0]); end
        end
        if (got_cyc.size() >= 4) begin
            checks++; if (got_cyc[0] - start_cyc != 1) begin errors++; $display("FAIL basic_first_latency got=%0d exp=1", got_cyc[0] - start_cyc); end
            checks++; if (got_cyc[3] - got_cyc[0] != 3) begin errors++; $display("FAIL basic_back_to_back got=%0d exp=3", got_cyc[3] - got_cyc[0]); end
            checks++; if (done_cyc - got_cyc[0] != 6) begin errors++; $display("FAIL basic_done_latency got=%0d exp=6", done_cyc - got_cyc[0]); end
        end
        run = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_zero_len();
        clear_tb();
        bq.push_back(mk_line(32'h5));
        start(64'd0, 42'h55);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_hold got=%b exp=1", done); end
        checks++; if (rd_count != 0) begin errors++; $display("FAIL zero_rd_en got=%0d exp=0", rd_count); end
        checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL zero_valid got=%0d exp=0", got_addr.size()); end
        run = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clear got=%b exp=0", done); end
        bq.delete();
    endtask

    task automatic test_stall();
        bit ok;
        clear_tb();
        for (int i = 0; i < 8; i++) bq.push_back(mk_line(32'hC000_0000 + i));
        auto_rsp = 1'b1;
        start(64'd8, 42'h2000);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            buf_gate    = ((t / 3) % 2) == 0;
            c1TxAlmFull = (t >= 4) && (t < 9);
            tick();
            if (done_cyc >= 0) begin
                ok = 1'b1;
                break;
            end
        end
        c1TxAlmFull = 1'b0;
        buf_gate    = 1'b1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_done_timeout got=%b exp=1", ok); end
        checks++; if (got_addr.size() != 8) begin errors++; $display("FAIL stall_req_count got=%0d exp=8", got_addr.size()); end
        checks++; if (rd_count != 8) begin errors++; $display("FAIL stall_pop_count got=%0d exp=8", rd_count); end
        checks++; if (alm_viol != 0) begin errors++; $display("FAIL stall_pop_while_almfull got=%0d exp=0", alm_viol); end
        for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
            checks++; if (got_addr[i] !== 42'h2000 + i) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, got_addr[i], 42'h2000 + i); end
            checks++; if (got_data[i] !== mk_line(32'hC000_0000 + i)) begin errors++; $display("FAIL stall_data[%0d] got=%h", i, got_data[i][31:0]); end
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [CLW-1:0] exp_addr [3] = '{42'h3FF_FFFF_FFFE, 42'h3FF_FFFF_FFFF, 42'h0};
        bit ok;
        clear_tb();
        for (int i = 0; i < 3; i++) bq.push_back(mk_line(32'hD000_0000 + i));
        auto_rsp = 1'b1;
        start(64'd3, 42'h3FF_FFFF_FFFE);
        wait_done(40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_done_timeout got=%b exp=1", ok); end
        checks++; if (got_addr.size() != 3) begin errors++; $display("FAIL wrap_req_count got=%0d exp=3", got_addr.size()); end
        for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
            checks++; if (got_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, got_addr[i], exp_addr[i]); end
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_tb();
        for (int i = 0; i < 6; i++) bq.push_back(mk_line(32'hE000_0000 + i));
        auto_rsp = 1'b1;
        start(64'd6, 42'h300);
        for (int t = 0; t < 30; t++) begin
            tick();
            if (got_addr.size() >= 3) break;
        end
        checks++; if (got_addr.size() != 3) begin errors++; $display("FAIL rstmid_pre_count got=%0d exp=3", got_addr.size()); end
        reset = 1'b0;
        #1;
        checks++; if (c1Tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", c1Tx_valid); end
        checks++; if (c1Tx_addr !== '0) begin errors++; $display("FAIL rstmid_addr got=%h exp=0", c1Tx_addr); end
        checks++; if (c1Tx_mdata !== 16'd0) begin errors++; $display("FAIL rstmid_mdata got=%h exp=0", c1Tx_mdata); end
        checks++; if (c1Tx_data !== '0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", c1Tx_data[31:0]); end
        checks++; if (buffer_rd_enable !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got=%b exp=0", buffer_rd_enable); end
        run = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        got_addr.delete();
        rd_count = 0;
        for (int t = 0; t < 3; t++) tick();
        checks++; if (got_addr.size() != 0 || rd_count != 0) begin errors++; $display("FAIL rstmid_no_req_after got=%0d exp=0", got_addr.size() + rd_count); end

        clear_tb();
        bq.push_back(mk_line(32'hF000_0000));
        bq.push_back(mk_line(32'hF000_0001));
        auto_rsp = 1'b1;
        start(64'd2, 42'h400);
        wait_done(40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL restart_done_timeout got=%b exp=1", ok); end
        checks++; if (got_addr.size() != 2) begin errors++; $display("FAIL restart_req_count got=%0d exp=2", got_addr.size()); end
        for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
            checks++; if (got_mdata[i] !== 16'(i)) begin errors++; $display("FAIL restart_mdata[%0d] got=%0d exp=%0d", i, got_mdata[i], i); end
            checks++; if (got_addr[i] !== 42'h400 + i) begin errors++; $display("FAIL restart_addr[%0d] got=%h exp=%h", i, got_addr[i], 42'h400 + i); end
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_extra_rsp();
        bit ok;
        clear_tb();
        bq.push_back(mk_line(32'h1111_0000));
        bq.push_back(mk_line(32'h1111_0001));
        auto_rsp = 1'b1;
        start(64'd2, 42'h500);
        wait_done(40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL extra_done_timeout got=%b exp=1", ok); end
        if (got_cyc.size() >= 1) begin
            checks++; if (done_cyc - got_cyc[0] != 4) begin errors++; $display("FAIL extra_done_latency got=%0d exp=4", done_cyc - got_cyc[0]); end
        end
        auto_rsp  = 1'b0;
        force_rsp = 1'b1;
        tick();
        tick();
        force_rsp = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL extra_done_hold got=%b exp=1", done); end
        run = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL extra_done_clear got=%b exp=0", done); end
        force_rsp = 1'b1;
        tick();
        tick();
        force_rsp = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL extra_idle_rsp got=%b exp=0", done); end
        checks++; if (rd_count != 2 || got_addr.size() != 2) begin errors++; $display("FAIL extra_req_count got=%0d/%0d exp=2/2", rd_count, got_addr.size()); end

        clear_tb();
        bq.push_back(mk_line(32'h2222_0000));
        bq.push_back(mk_line(32'h2222_0001));
        start(64'd2, 42'h600);
        for (int t = 0; t < 6; t++) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL extra_wait_no_rsp got=%b exp=0", done); end
        checks++; if (got_addr.size() != 2) begin errors++; $display("FAIL extra_second_req_count got=%0d exp=2", got_addr.size()); end
        force_rsp = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL extra_one_rsp got=%b exp=0", done); end
        tick();
        force_rsp = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL extra_two_rsp got=%b exp=1", done); end
        run = 1'b0;
        tick();
    endtask

    initial begin
        reset            = 1'b0;
        run              = 1'b0;
        data_length      = 64'd0;
        first_clAddr     = '0;
        empty_n          = 1'b0;
        buffer_data      = '0;
        c1TxAlmFull      = 1'b0;
        c1Rx_wrRsp_valid = 1'b0;
        cyc              = 0;
        start_cyc        = 0;
        clear_tb();

        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_extra_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
